// File: rtl/oddr_lanes.sv
// -----------------------------------------------------------------------------
// oddr_lanes
//
// Purpose:
//   Forwards NLANES double-data-rate output pads from a single clock. Each
//   beat carries two bits per lane: the clock-high half and the clock-low half.
//   Every lane uses an XOR encoder built from two rising-edge registers and one
//   falling-edge register. The pad is the XOR of the rising encoder register
//   and the falling register, so each clock edge changes exactly one register
//   and there is no clock-gated mux. A one-entry skid buffer holds a beat that
//   arrives while the output stage is busy. An optional training burst drives
//   a high=1 / low=0 pattern on every lane.
//
// Optional feature:
//   ODDR_TRAIN_EN - when defined, adds i_train, o_training, the burst counter
//                   and the TRAIN state. When it is undefined, none of these
//                   exist.
//
// Ports:
//   i_clk       in   1          clock; both edges are used (pad rate = 2x)
//   i_reset_n   in   1          synchronous active-low reset (rising edge)
//   i_valid     in   1          a beat is offered on i_data
//   o_ready     out  1          registered; beat accepted on i_valid && o_ready
//   i_data      in   2*NLANES   lane k: bit 2k+1 = high half, bit 2k = low half
//   i_train     in   1          one-cycle training request (ODDR_TRAIN_EN)
//   o_training  out  1          high while a burst runs     (ODDR_TRAIN_EN)
//   o_pad       out  NLANES     DDR pad outputs, after INVERT_MASK
// -----------------------------------------------------------------------------
module oddr_lanes #(
   parameter int unsigned       NLANES       = 4,
   parameter logic [NLANES-1:0] INVERT_MASK  = {NLANES{1'b0}},
   parameter int unsigned       TRAIN_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2*NLANES-1:0]   i_data,
`ifdef ODDR_TRAIN_EN
   input  logic                  i_train,
   output logic                  o_training,
`endif
   output logic [NLANES-1:0]     o_pad
);

   // Catch illegal parameterisations at elaboration time.
   if ((NLANES < 1) || (NLANES > 32)) begin : g_bad_nlanes
      $error("oddr_lanes: NLANES must be 1..32");
   end
   if ((TRAIN_CYCLES < 2) || (TRAIN_CYCLES > 255)) begin : g_bad_train
      $error("oddr_lanes: TRAIN_CYCLES must be 2..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1
`ifdef ODDR_TRAIN_EN
      , ST_TRAIN = 2'd2
`endif
   } state_t;

`ifdef ODDR_TRAIN_EN
   // The counter is loaded at burst start and the burst ends when it reads zero.
   localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_CYCLES - 1);
`endif

   // Extract the clock-high bit of every lane from a beat.
   function automatic logic [NLANES-1:0] beat_high(input logic [2*NLANES-1:0] beat);
      logic [NLANES-1:0] res;
      res = {NLANES{1'b0}};
      for (int k = 0; k < NLANES; k++) begin
         res[k] = beat[2*k+1];
      end
      return res;
   endfunction

   // Extract the clock-low bit of every lane from a beat.
   function automatic logic [NLANES-1:0] beat_low(input logic [2*NLANES-1:0] beat);
      logic [NLANES-1:0] res;
      res = {NLANES{1'b0}};
      for (int k = 0; k < NLANES; k++) begin
         res[k] = beat[2*k];
      end
      return res;
   endfunction

   // Rising-edge encoder value: rise ^ fall must equal the wanted high bit.
   function automatic logic [NLANES-1:0] rise_encode(input logic [NLANES-1:0] high,
                                                     input logic [NLANES-1:0] fall);
      return high ^ fall;
   endfunction

   state_t               state_r;
   state_t               state_next_s;
   logic                 skid_vld_r;
   logic [2*NLANES-1:0]  skid_data_r;
   logic                 skid_vld_next_s;
   logic [2*NLANES-1:0]  skid_data_next_s;
   logic [NLANES-1:0]    rise_r;       // rising-edge encoder register
   logic [NLANES-1:0]    low_r;        // rising-edge copy of this cycle's low half
   logic [NLANES-1:0]    fall_r;       // falling-edge register: low_r ^ rise_r
   logic [NLANES-1:0]    rise_next_s;
   logic [NLANES-1:0]    hi_s;
   logic [NLANES-1:0]    lo_s;
   logic                 accept_s;
   logic                 train_next_s;
`ifdef ODDR_TRAIN_EN
   logic [7:0]           cnt_r;
   logic [7:0]           cnt_next_s;
`endif

   // Next-state, emit selection and skid bookkeeping for the coming cycle.
   always_comb begin
      accept_s         = i_valid && o_ready;
      train_next_s     = 1'b0;
`ifdef ODDR_TRAIN_EN
      cnt_next_s       = 8'd0;
      // A request during a burst is ignored, so the counter never restarts.
      if ((state_r != ST_TRAIN) && i_train) begin
         train_next_s = 1'b1;
         cnt_next_s   = TRAIN_LOAD;
      end else if ((state_r == ST_TRAIN) && (cnt_r != 8'd0)) begin
         train_next_s = 1'b1;
         cnt_next_s   = cnt_r - 8'd1;
      end else begin
         train_next_s = 1'b0;
         cnt_next_s   = 8'd0;
      end
`endif
      // The idle hold repeats the last emitted low half in both halves.
      hi_s             = low_r;
      lo_s             = low_r;
      skid_vld_next_s  = skid_vld_r;
      skid_data_next_s = skid_data_r;
      state_next_s     = ST_IDLE;
`ifdef ODDR_TRAIN_EN
      if (train_next_s) begin
         hi_s         = {NLANES{1'b1}};
         lo_s         = {NLANES{1'b0}};
         state_next_s = ST_TRAIN;
         // A beat accepted as the burst starts waits in the skid.
         if (accept_s) begin
            skid_vld_next_s  = 1'b1;
            skid_data_next_s = i_data;
         end else begin
            skid_vld_next_s  = skid_vld_r;
            skid_data_next_s = skid_data_r;
         end
      end else
`endif
      if (skid_vld_r) begin
         // A held beat always goes out before any new beat.
         hi_s             = beat_high(skid_data_r);
         lo_s             = beat_low(skid_data_r);
         skid_vld_next_s  = 1'b0;
         state_next_s     = ST_DATA;
      end else if (accept_s) begin
         // Zero-latency path: the accepted beat is on the pad after this edge.
         hi_s             = beat_high(i_data);
         lo_s             = beat_low(i_data);
         state_next_s     = ST_DATA;
      end else begin
         state_next_s     = ST_IDLE;
      end

      // A lane parked in IDLE already satisfies rise ^ fall == low, so the
      // rising register stays unchanged and nothing toggles.
      if ((state_r == ST_IDLE) && (state_next_s == ST_IDLE)) begin
         rise_next_s = rise_r;
      end else begin
         rise_next_s = rise_encode(hi_s, fall_r);
      end
   end

   // Rising-edge state: FSM, skid, ready, burst counter and the encoder registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_r     <= ST_IDLE;
         o_ready     <= 1'b0;
         skid_vld_r  <= 1'b0;
         skid_data_r <= {2*NLANES{1'b0}};
         rise_r      <= {NLANES{1'b0}};
         low_r       <= {NLANES{1'b0}};
`ifdef ODDR_TRAIN_EN
         cnt_r       <= 8'd0;
         o_training  <= 1'b0;
`endif
      end else begin
         state_r     <= state_next_s;
         o_ready     <= !skid_vld_next_s && !train_next_s;
         skid_vld_r  <= skid_vld_next_s;
         skid_data_r <= skid_data_next_s;
         rise_r      <= rise_next_s;
         low_r       <= lo_s;
`ifdef ODDR_TRAIN_EN
         cnt_r       <= cnt_next_s;
         o_training  <= train_next_s;
`endif
      end
   end

   // Falling-edge register. It resolves to zero on the first falling edge
   // after reset because rise_r and low_r are both cleared.
   always_ff @(negedge i_clk) begin
      fall_r <= low_r ^ rise_r;
   end

   // Exactly one register changes per edge, so the XOR output is glitch-free.
   assign o_pad = rise_r ^ fall_r ^ INVERT_MASK;

endmodule

// File: tb/tb_oddr_lanes.sv
// -----------------------------------------------------------------------------
// tb_oddr_lanes
//
// Directed test of oddr_lanes with NLANES=4, INVERT_MASK=4'b0010 and
// TRAIN_CYCLES=16. Inputs change in the clock-low phase. The pad is sampled
// 2 time units after each rising edge (high half) and 7 time units after it
// (low half). Expected pad values are hand-computed with the mask applied.
// The training steps are present only when ODDR_TRAIN_EN is defined.
// -----------------------------------------------------------------------------
module tb_oddr_lanes;

   localparam logic [3:0] MASK   = 4'b0010;
   localparam logic [7:0] BEAT_S = 8'b10_01_11_00; // hi 1010 lo 0110 raw
   localparam logic [7:0] BEAT_F = 8'hFF;          // hi 1111 lo 1111 raw
   localparam logic [7:0] BEAT_P = 8'b01_10_00_11; // hi 0101 lo 1001 raw
   localparam logic [7:0] BEAT_A = 8'b11_00_10_01; // hi 1010 lo 1001 raw
   localparam logic [7:0] BEAT_B = 8'b00_11_01_10; // hi 0101 lo 0110 raw

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_ready;
   logic [3:0] o_pad;
`ifdef ODDR_TRAIN_EN
   logic       i_train;
   logic       o_training;
   logic       trn;
`endif

   int         total = 0;
   int         bad   = 0;
   logic [3:0] pad_hi;
   logic [3:0] pad_lo;
   logic       rdy;

   always #5 i_clk = ~i_clk;

   oddr_lanes #(
      .NLANES       (4),
      .INVERT_MASK  (MASK),
      .TRAIN_CYCLES (16)
   ) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
`ifdef ODDR_TRAIN_EN
      .i_train    (i_train),
      .o_training (o_training),
`endif
      .o_pad      (o_pad)
   );

   // One clock: sample the high half, then the low half, and return in the low phase.
   task automatic cyc();
      @(posedge i_clk);
      #2;
      pad_hi = o_pad;
      rdy    = o_ready;
`ifdef ODDR_TRAIN_EN
      trn    = o_training;
`endif
      #5;
      pad_lo = o_pad;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pads(input string tag, input logic [3:0] exp_hi, input logic [3:0] exp_lo);
      chk({tag, "_hi"}, {28'd0, pad_hi}, {28'd0, exp_hi});
      chk({tag, "_lo"}, {28'd0, pad_lo}, {28'd0, exp_lo});
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      i_data    = 8'h00;
`ifdef ODDR_TRAIN_EN
      i_train   = 1'b0;
`endif

      // Reset: the pad equals the mask from the first falling edge on.
      cyc();
      chk("rst0_lo", {28'd0, pad_lo}, {28'd0, MASK});
      cyc();
      chk_pads("rst1", MASK, MASK);
      chk("rst1_rdy", {31'd0, rdy}, 32'd0);

      // Release: o_ready rises after the first rising edge with reset high.
      i_reset_n = 1'b1;
      cyc();
      chk("rel_rdy", {31'd0, rdy}, 32'd1);
      chk_pads("rel", MASK, MASK);

      // Stream three identical beats with zero latency.
      i_valid = 1'b1;
      i_data  = BEAT_S;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_pads($sformatf("strm%0d", i), 4'b1000, 4'b0100);
         chk($sformatf("strm%0d_rdy", i), {31'd0, rdy}, 32'd1);
      end

      // One all-ones beat, then idle: the pad holds 1 (masked) in both halves.
      i_data = BEAT_F;
      cyc();
      chk_pads("ff", 4'b1101, 4'b1101);
      i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_pads($sformatf("ffidle%0d", i), 4'b1101, 4'b1101);
      end

      // Mixed pattern, then idle holds its low half.
      i_valid = 1'b1;
      i_data  = BEAT_P;
      cyc();
      chk_pads("pat", 4'b0111, 4'b1011);
      i_valid = 1'b0;
      cyc();
      chk_pads("patidle", 4'b1011, 4'b1011);

`ifdef ODDR_TRAIN_EN
      // Training burst with i_valid held high: beat A goes to the skid.
      i_valid = 1'b1;
      i_data  = BEAT_A;
      i_train = 1'b1;
      cyc();
      chk("tr1_rdy", {31'd0, rdy}, 32'd0);
      chk("tr1_trn", {31'd0, trn}, 32'd1);
      chk_pads("tr1", 4'b1101, 4'b0010);
      i_data = BEAT_B;
      for (int i = 2; i <= 16; i++) begin
         // A second request in burst cycle 8 must not extend the burst.
         i_train = (i == 8);
         cyc();
         chk($sformatf("tr%0d_rdy", i), {31'd0, rdy}, 32'd0);
         chk($sformatf("tr%0d_trn", i), {31'd0, trn}, 32'd1);
         chk_pads($sformatf("tr%0d", i), 4'b1101, 4'b0010);
      end
      i_train = 1'b0;
      cyc();
      chk("trend_rdy", {31'd0, rdy}, 32'd1);
      chk("trend_trn", {31'd0, trn}, 32'd0);
      chk_pads("skidA", 4'b1000, 4'b1011);
      cyc();
      chk_pads("postB", 4'b0111, 4'b0100);
      i_data = BEAT_F;
      cyc();
      chk_pads("postF", 4'b1101, 4'b1101);

      // Reset in burst cycle 5 with the skid full: the held beat is discarded.
      i_data  = BEAT_A;
      i_train = 1'b1;
      cyc();
      i_train = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
      end
      chk("mid_trn", {31'd0, trn}, 32'd1);
      i_reset_n = 1'b0;
      cyc();
      chk("abort_trn", {31'd0, trn}, 32'd0);
`else
      // Reset with a stream in flight.
      i_valid = 1'b1;
      i_data  = BEAT_A;
      cyc();
      chk_pads("beatA", 4'b1000, 4'b1011);
      i_reset_n = 1'b0;
      cyc();
`endif
      chk("abort_rdy", {31'd0, rdy}, 32'd0);
      chk("abort_lo", {28'd0, pad_lo}, {28'd0, MASK});
      i_reset_n = 1'b1;
      i_valid   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_pads($sformatf("after%0d", i), MASK, MASK);
         chk($sformatf("after%0d_rdy", i), {31'd0, rdy}, 32'd1);
`ifdef ODDR_TRAIN_EN
         chk($sformatf("after%0d_trn", i), {31'd0, trn}, 32'd0);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oddr_lanes.md
ODDR_LANES -- requirements
Module: oddr_lanes

Interface
REQ-001 The block SHALL have parameter NLANES, default 4, giving the number of DDR output pads (1..32).
REQ-002 The block SHALL have parameter INVERT_MASK, default 0, NLANES bits wide; a set bit k inverts pad k at the output.
REQ-003 The block SHALL have parameter TRAIN_CYCLES, default 16, giving the training-burst length in clocks (2..255).
REQ-004 The block SHALL have a single clock, i_clk, with both edges used; reset is synchronous and active-low, i_reset_n, sampled on rising i_clk.
REQ-005 Port i_clk: input, 1 bit, the clock; forwarded DDR rate is 2x i_clk.
REQ-006 Port i_reset_n: input, 1 bit, synchronous active-low reset.
REQ-007 Port i_valid: input, 1 bit, a beat is offered on i_data.
REQ-008 Port o_ready: output, 1 bit, registered; the beat is accepted at a rising edge when i_valid && o_ready.
REQ-009 Port i_data: input, 2*NLANES bits; lane k bit 2k+1 drives the clock-high half, bit 2k the clock-low half.
REQ-010 Port i_train: input, 1 bit, single-cycle request for a training burst (present only under ODDR_TRAIN_EN).
REQ-011 Port o_training: output, 1 bit, high while a burst is in progress (present only under ODDR_TRAIN_EN).
REQ-012 Port o_pad: output, NLANES bits, the DDR pad outputs.

Function
REQ-013 Each lane SHALL use a glitch-free XOR encoding: two rising-edge registers and one falling-edge register copying the rising-edge parity, with the pad equal to their XOR, so there is no clock-gated mux.
REQ-014 The output stage SHALL have a one-entry skid buffer; o_ready SHALL equal "skid empty and not training" registered.
REQ-015 A beat accepted at rising edge N with the skid empty SHALL drive the pad with bit 2k+1 while i_clk is high after edge N and with bit 2k while i_clk is low before edge N+1 (zero-cycle output latency).
REQ-016 A beat accepted while the output stage is blocked SHALL be held in the skid and emitted, in order, in the first cycle the stage is free; no beat SHALL be dropped or duplicated.
REQ-017 In any cycle with no beat available, each lane SHALL drive its last emitted clock-low value in both halves (idle hold, no toggling).
REQ-018 INVERT_MASK SHALL apply after the encoding; idle hold and reset values SHALL be inverted accordingly.
REQ-019 The state machine SHALL have three states: IDLE (no beat), DATA (beat emitted this cycle), TRAIN; IDLE<->DATA follow beat availability; entry to TRAIN is only via REQ-024.

Reset
REQ-020 While i_reset_n is low at a rising edge, the block SHALL set o_ready=0, empty the skid, set the state to IDLE, clear o_training, and clear the training counter.
REQ-021 The pad SHALL equal INVERT_MASK[k] in both halves from the falling edge following the first reset edge.
REQ-022 o_ready SHALL rise one cycle after the first rising edge with i_reset_n high.
REQ-023 A reset asserted mid-burst or with the skid full SHALL abort the burst and discard the held beat.

Configuration
REQ-024 With ODDR_TRAIN_EN defined, i_train sampled high in any state SHALL, at the next edge, set o_training, drop o_ready, and emit TRAIN_CYCLES cycles of pattern high=1, low=0 on every lane, then return to IDLE/DATA; a held skid beat SHALL be emitted after the burst.
REQ-025 An i_train pulse during a burst SHALL be ignored and SHALL NOT restart the counter.
REQ-026 Without ODDR_TRAIN_EN, the ports i_train and o_training, the counter, and the TRAIN state SHALL be absent; o_ready SHALL depend only on the skid.

Verification
REQ-027 Reset, NLANES=4, INVERT_MASK=4'b0010: pads read 0,1,0,0 in both halves; o_ready=1 one cycle after release.
REQ-028 Stream i_data=8'b10_01_11_00 for 3 beats with i_valid held: lane0 emits 0/0, lane1 1/1, lane2 0/1 (high/low), lane3 1/0 each cycle; no glitch at the rising edges.
REQ-029 One beat 8'hFF followed by i_valid=0: pads stay at 1 in both halves for all later cycles.
REQ-030 ODDR_TRAIN_EN, TRAIN_CYCLES=16, i_train pulse with i_valid held high: o_ready=0 for 16 cycles, pads toggle 1/0; one skid beat is emitted first after the burst, followed by the stream with no loss.
REQ-031 A reset pulse at burst cycle 5 with the skid full: o_training=0, pads at INVERT_MASK, and the held beat is never emitted.
REQ-032 Formal check: for every lane, pad == registered high bit while i_clk is high and == registered low bit while i_clk is low, under the assumption that inputs are stable except at rising edges.
